// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-seg driver with dead-time, per-frame latch, LZ blanking and blink
module seg7_scan_driver #(
  parameter int BLANK_TICKS = 1,
  parameter int SHOW_TICKS = 3,
  parameter int BLINK_TICKS = 250,
  parameter int AN_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        tick,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);
  localparam int MAXT = BLANK_TICKS > SHOW_TICKS ? BLANK_TICKS : SHOW_TICKS;
  localparam int PW = MAXT > 1 ? $clog2(MAXT) : 1;
  localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] B_LAST = PW'(BLANK_TICKS > 0 ? BLANK_TICKS - 1 : 0);
  localparam logic [PW-1:0] S_LAST = PW'(SHOW_TICKS - 1);
  localparam logic [BW-1:0] K_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;
  localparam logic AN_INV = AN_ACTIVE_LOW != 0;
  localparam logic SEG_INV = SEG_ACTIVE_LOW != 0;
  logic [0:0]    state;
  logic [1:0]    digit, next_digit;
  logic [PW-1:0] phase;
  logic [BW-1:0] bcnt;
  logic          bhide;
  logic [15:0]   v_l;
  logic [3:0]    dp_l, bl_l, nib, an_raw;
  logic          lz_l, b_done, s_done, enter_show, latch, hide, on;
  logic [6:0]    dec, seg_raw;
  always_comb begin
    b_done = state == ST_BLANK && (BLANK_TICKS == 0 || phase == B_LAST);
    s_done = state == ST_SHOW && phase == S_LAST;
    next_digit = s_done ? digit + 2'd1 : digit;
    // with no dead-time a finished digit hands straight over to the next SHOW
    enter_show = tick && (b_done || (s_done && BLANK_TICKS == 0));
    latch = enter_show && next_digit == 2'd0;
  end
  always_comb begin
    nib = v_l[{digit, 2'b00} +: 4];
    case (nib)
      4'd0: dec = 7'b0111111;
      4'd1: dec = 7'b0000110;
      4'd2: dec = 7'b1011011;
      4'd3: dec = 7'b1001111;
      4'd4: dec = 7'b1100110;
      4'd5: dec = 7'b1101101;
      4'd6: dec = 7'b1111101;
      4'd7: dec = 7'b0000111;
      4'd8: dec = 7'b1111111;
      4'd9: dec = 7'b1101111;
      default: dec = 7'b1000000;
    endcase
    // a digit is a leading zero when it and everything to its left is zero
    hide = (lz_l && digit != 2'd0 && (v_l >> {digit, 2'b00}) == 16'h0) || (bhide && bl_l[digit]);
    on = state == ST_SHOW && !hide;
    an_raw = on ? 4'b0001 << digit : 4'b0000;
    seg_raw = on ? dec : 7'b0000000;
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= ST_BLANK;
      digit <= 2'd0;
      phase <= '0;
      bcnt <= '0;
      bhide <= 1'b0;
      v_l <= 16'h0;
      dp_l <= 4'h0;
      bl_l <= 4'h0;
      lz_l <= 1'b0;
      an <= {4{AN_INV}};
      seg <= {7{SEG_INV}};
      dp <= SEG_INV;
      frame_start <= 1'b0;
    end else begin
      frame_start <= latch;
      an <= an_raw ^ {4{AN_INV}};
      seg <= seg_raw ^ {7{SEG_INV}};
      dp <= (on && dp_l[digit]) ^ SEG_INV;
      if (tick) begin
        bcnt <= bcnt == K_LAST ? '0 : bcnt + 1'b1;
        bhide <= bcnt == K_LAST ? ~bhide : bhide;
        state <= enter_show ? ST_SHOW : s_done ? ST_BLANK : state;
        phase <= b_done || s_done ? '0 : phase + 1'b1;
        digit <= next_digit;
      end
      if (latch) begin
        v_l <= value;
        dp_l <= dp_mask;
        bl_l <= blink_mask;
        lz_l <= lz_blank;
      end
    end
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes the tick pulse from the clock divider and the 16-bit BCD mm:ss value from the time counter.
- Multiplexes the value onto a 4-digit common-anode seven-segment display.
- Owns its own digit-scan sequencer with dead-time between digits to prevent ghosting.
- Latches the value once per frame so a digit never tears mid-frame; supports leading-zero blanking, per-digit decimal points and per-digit blinking for set mode.

Parameters:
- BLANK_TICKS, 1, ticks of all-anodes-off dead-time before each digit; 0 disables dead-time.
- SHOW_TICKS, 3, ticks each digit is driven; must be >= 1.
- BLINK_TICKS, 250, ticks per blink half-period.
- AN_ACTIVE_LOW, 1, 1 means an=0 enables a digit.
- SEG_ACTIVE_LOW, 1, 1 means seg/dp=0 lights a segment.

Ports:
- clk  in  1  system clock.
- clr_n  in  1  reset: synchronous, active-low.
- tick  in  1  one-cycle enable pulse from the divider; may be held high to step every cycle.
- value  in  16  BCD digits, [3:0] digit0 (rightmost) through [15:12] digit3.
- dp_mask  in  4  bit d lights the DP of digit d.
- blink_mask  in  4  bit d blinks digit d.
- lz_blank  in  1  enables leading-zero suppression.
- an  out  4  digit enables, an[d] = digit d.
- seg  out  7  {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- frame_start  out  1  one-cycle pulse when digit0 enters SHOW.

Behaviour:
- All state advances only on clk edges with tick=1, except the frame_start pulse width and reset.
- Reset (clr_n=0 at an edge):
  - state=BLANK, digit=0, phase counter=0, blink counter=0, blink phase=visible.
  - Latched value, masks and lz_blank = 0.
  - an = all inactive (4'b1111 when AN_ACTIVE_LOW), seg and dp = dark, frame_start=0.
  - Reset asserted mid-frame aborts the frame. The first frame after release starts at digit0 BLANK.
- States:
  - BLANK: an all inactive, seg/dp dark. After BLANK_TICKS ticks, go to SHOW. If BLANK_TICKS=0, go to SHOW on the first tick.
  - SHOW: drive digit. After SHOW_TICKS ticks: digit <= digit+1 (3 wraps to 0), go to BLANK.
- Frame latch:
  - On the transition into SHOW with digit=0, latch value, dp_mask, blink_mask and lz_blank.
  - frame_start=1 for exactly that clk cycle.
  - Input changes between latches have no visible effect.
- Frame length = 4*(BLANK_TICKS+SHOW_TICKS) ticks.
- Outputs are registered: an/seg/dp reflect a state change one clk after the tick that caused it.
- Decode, active-high {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 10..15 = 1000000 ('-'); invalid BCD is shown as a dash, never as hex.
- Leading-zero blanking (latched lz_blank=1):
  - digit3 is blanked if it is 0.
  - digit2 is blanked if digits 3 and 2 are both 0.
  - digit1 is blanked if digits 3, 2 and 1 are all 0.
  - digit0 is never blanked.
  - A blanked digit keeps its anode inactive during its SHOW window, and its DP is also dark.
- Blink:
  - The blink counter counts ticks independently of the scan and wraps at BLINK_TICKS-1.
  - The blink phase toggles on each wrap.
  - In the hidden phase, any digit with a latched blink_mask bit set keeps its anode inactive, including the DP.
- Simultaneous events: leading-zero blanking and blink both suppress; suppression is the OR of the two.
- Polarity is applied only at the output registers.

Test Plan:
- BLANK_TICKS=1, SHOW_TICKS=2, tick=1 every cycle, value=16'h1234, lz_blank=0, masks=0 -> repeating 12-cycle frame.
  - 1 cycle an=1111, then 2 cycles an=1110 seg=~7'b1100110 ('4').
  - Then blank, then an=1101 '3', an=1011 '2', an=0111 '1'.
  - frame_start pulses once per 12 cycles.
- lz_blank=1, value=16'h0005 -> digits 3..1 keep an=1111 through their SHOW windows; digit0 shows '5'. With value=16'h0000, only digit0 shows '0'.
- value changed from 16'h1234 to 16'h5678 while digit2 is showing -> digits 2 and 3 still show 2 and 1 in this frame; 8,7,6,5 appear only after the next frame_start.
- BLINK_TICKS=4, blink_mask=4'b0011 -> digits 1 and 0 go dark for 4 ticks out of every 8, while digits 3 and 2 are unaffected. dp_mask=4'b0100 -> dp lit only during digit2 SHOW.
- value=16'h00A0 -> digit1 shows seg=~7'b1000000 ('-').
- clr_n=0 for one edge mid-digit2 SHOW -> next cycle an=1111, frame_start=0. After release, the frame restarts at digit0 with BLANK first.
